// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage pipeline
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        EXE_RegWrite,
  input  logic        EXE_DatatoReg,
  input  logic [4:0]  EXE_register_write_address,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_register_write_address,
  input  logic        EXE_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        IF_ID_flush,
  output logic        ID_EXE_bubble,
  output logic        pipe_hold,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [1:0]  state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_FROZEN   = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  r_state_nxt;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  logic        w_exe_dst_nz;
  logic        w_mem_dst_nz;
  logic        w_loaduse;
  logic        w_memwait;
  logic        w_freeze;
  logic        w_advance;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // EXE stage (the instruction about to be in MEM) wins over MEM (about to be in WB)
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       exe_hit_en,
                                         input logic [4:0] exe_dst,
                                         input logic       mem_hit_en,
                                         input logic [4:0] mem_dst);
    if (exe_hit_en && (src == exe_dst))      return FWD_MEM;
    else if (mem_hit_en && (src == mem_dst)) return FWD_WB;
    else                                     return FWD_NONE;
  endfunction

  assign w_exe_dst_nz = (EXE_register_write_address != 5'd0);
  assign w_mem_dst_nz = (MEM_register_write_address != 5'd0);

  assign w_loaduse = EXE_RegWrite & EXE_DatatoReg & w_exe_dst_nz &
                     ((ID_uses_rs & (ID_rs == EXE_register_write_address)) |
                      (ID_uses_rt & (ID_rt == EXE_register_write_address)));
  assign w_memwait = mem_req & ~mem_ready;

  // Anything that stops ID/EXE and later latches from moving this cycle
  assign w_freeze  = reset | ~cpu_en | w_memwait;
  assign w_advance = ~w_freeze;

  assign w_fwd_a = fwd_sel(ID_rs, EXE_RegWrite & w_exe_dst_nz, EXE_register_write_address,
                           MEM_RegWrite & w_mem_dst_nz, MEM_register_write_address);
  assign w_fwd_b = fwd_sel(ID_rt, EXE_RegWrite & w_exe_dst_nz, EXE_register_write_address,
                           MEM_RegWrite & w_mem_dst_nz, MEM_register_write_address);

  // Prioritised Mealy control: freeze > taken branch > load-use > normal
  always_comb begin
    PC_en         = 1'b1;
    IF_ID_en      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EXE_bubble = 1'b0;
    pipe_hold     = 1'b0;
    if (w_freeze) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      pipe_hold = 1'b1;
    end else if (EXE_branch_taken) begin
      IF_ID_flush   = 1'b1;
      ID_EXE_bubble = 1'b1;
    end else if (w_loaduse) begin
      PC_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EXE_bubble = 1'b1;
    end
  end

  // Next-state: a frozen pipe always restarts through RUN, never straight into MEM_WAIT
  always_comb begin
    r_state_nxt = r_state;
    if (!cpu_en) begin
      r_state_nxt = ST_FROZEN;
    end else begin
      case (r_state)
        ST_RUN:      r_state_nxt = w_memwait ? ST_MEM_WAIT : ST_RUN;
        ST_MEM_WAIT: r_state_nxt = w_memwait ? ST_MEM_WAIT : ST_RUN;
        ST_FROZEN:   r_state_nxt = ST_RUN;
        default:     r_state_nxt = ST_RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= r_state_nxt;
  end

  // Forward selects travel with the instruction into EXE; a bubble carries no forwarding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
    end else if (w_advance) begin
      r_fwd_a <= ID_EXE_bubble ? FWD_NONE : w_fwd_a;
      r_fwd_b <= ID_EXE_bubble ? FWD_NONE : w_fwd_b;
    end
  end

  // Saturating performance counters: fetch-stall cycles and branch-flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (cpu_en && !PC_en && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
      if (IF_ID_flush && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign state       = r_state;
  assign ForwardA    = r_fwd_a;
  assign ForwardB    = r_fwd_b;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table and scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  // control bundle order: {PC_en, IF_ID_en, IF_ID_flush, ID_EXE_bubble, pipe_hold}
  localparam logic [4:0] FRZ = 5'b00001;
  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] BR  = 5'b11110;
  localparam logic [4:0] LU  = 5'b00010;

  typedef struct {
    logic       rst, en;
    logic [4:0] rs, rt;
    logic       urs, urt, exw, exl;
    logic [4:0] exa;
    logic       mw;
    logic [4:0] ma;
    logic       br, mreq, mrdy;
    logic [4:0] ctl;
    logic [1:0] nst, nfa, nfb;
  } vec_t;

  typedef struct {
    logic [1:0]  st, fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, cpu_en;
  logic [4:0] ID_rs, ID_rt;
  logic ID_uses_rs, ID_uses_rt, EXE_RegWrite, EXE_DatatoReg;
  logic [4:0] EXE_register_write_address;
  logic MEM_RegWrite;
  logic [4:0] MEM_register_write_address;
  logic EXE_branch_taken, mem_req, mem_ready;
  logic PC_en, IF_ID_en, IF_ID_flush, ID_EXE_bubble, pipe_hold;
  logic [1:0] ForwardA, ForwardB, state;
  logic [31:0] stall_count, flush_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  exp_t q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .EXE_RegWrite(EXE_RegWrite), .EXE_DatatoReg(EXE_DatatoReg),
    .EXE_register_write_address(EXE_register_write_address),
    .MEM_RegWrite(MEM_RegWrite), .MEM_register_write_address(MEM_register_write_address),
    .EXE_branch_taken(EXE_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_bubble(ID_EXE_bubble), .pipe_hold(pipe_hold),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  function automatic vec_t mk(logic rst, logic en, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic exw, logic exl, logic [4:0] exa,
                              logic mw, logic [4:0] ma, logic br, logic mreq, logic mrdy,
                              logic [4:0] ctl, logic [1:0] nst, logic [1:0] nfa, logic [1:0] nfb);
    vec_t v;
    v.rst = rst; v.en = en; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.exw = exw; v.exl = exl; v.exa = exa; v.mw = mw; v.ma = ma;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy;
    v.ctl = ctl; v.nst = nst; v.nfa = nfa; v.nfb = nfb;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one vector, check Mealy outputs in the same cycle, then check registered results after the edge
  task automatic run_vec(vec_t v, int idx);
    exp_t e, got;
    logic [4:0] ctl_act;
    reset = v.rst; cpu_en = v.en;
    ID_rs = v.rs; ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
    EXE_RegWrite = v.exw; EXE_DatatoReg = v.exl; EXE_register_write_address = v.exa;
    MEM_RegWrite = v.mw; MEM_register_write_address = v.ma;
    EXE_branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    #1;
    ctl_act = {PC_en, IF_ID_en, IF_ID_flush, ID_EXE_bubble, pipe_hold};
    check($sformatf("ctl[%0d]", idx), {27'd0, ctl_act}, {27'd0, v.ctl});
    if (v.rst) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (v.en && !v.ctl[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (v.ctl[2] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
    end
    e.st = v.nst; e.fa = v.nfa; e.fb = v.nfb; e.sc = m_stall; e.fc = m_flush;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard[%0d]: queue empty", idx);
    end else begin
      got = q.pop_front();
      check($sformatf("state[%0d]", idx), {30'd0, state}, {30'd0, got.st});
      check($sformatf("fwdA[%0d]", idx), {30'd0, ForwardA}, {30'd0, got.fa});
      check($sformatf("fwdB[%0d]", idx), {30'd0, ForwardB}, {30'd0, got.fb});
      check($sformatf("stall_count[%0d]", idx), stall_count, got.sc);
      check($sformatf("flush_count[%0d]", idx), flush_count, got.fc);
    end
  endtask

  initial begin
    // rst en  rs rt urs urt exw exl exa mw ma br mreq mrdy  ctl  st fa fb
    tbl.push_back(mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, FRZ, 0,0,0)); // reset
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, NRM, 0,0,0)); // idle
    tbl.push_back(mk(0,1, 2,0, 1,0, 1,1,2, 0,0, 0,0,0, LU,  0,0,0)); // lw $2 -> add rs=2
    tbl.push_back(mk(0,1, 2,0, 1,0, 0,0,0, 1,2, 0,0,0, NRM, 0,2,0)); // load now in MEM
    tbl.push_back(mk(0,1, 2,0, 1,0, 1,1,2, 0,0, 1,0,0, BR,  0,0,0)); // branch beats loaduse
    tbl.push_back(mk(0,1, 5,5, 1,1, 1,0,5, 1,5, 0,0,0, NRM, 0,1,1)); // EXE+MEM hit $5
    tbl.push_back(mk(0,1, 5,5, 1,1, 0,0,0, 1,5, 0,0,0, NRM, 0,2,2)); // only MEM hit
    tbl.push_back(mk(0,1, 0,0, 1,1, 1,1,0, 1,0, 0,0,0, NRM, 0,0,0)); // $0 never hazards
    tbl.push_back(mk(0,1, 3,0, 1,0, 1,0,3, 0,0, 0,0,0, NRM, 0,1,0)); // A from EXE
    for (int i = 0; i < 3; i++)                                       // 3-cycle memory wait
      tbl.push_back(mk(0,1, 0,5, 0,1, 1,0,5, 0,0, 0,1,0, FRZ, 1,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 0,1,1, NRM, 0,0,0)); // memory completes
    tbl.push_back(mk(0,1, 3,0, 1,0, 1,0,3, 0,0, 0,1,1, NRM, 0,1,0)); // ready same cycle
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 1,1,0, FRZ, 1,1,0)); // memwait beats branch
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 1,1,0, FRZ, 2,1,0)); // freeze beats branch
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,1,0, FRZ, 2,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 0,1,0, FRZ, 0,1,0)); // FROZEN -> RUN first
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 0,1,0, FRZ, 1,1,0)); // then MEM_WAIT
    tbl.push_back(mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 0,1,0, FRZ, 0,0,0)); // reset mid wait
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, NRM, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Saturation: preload both counters near the top, then keep stalling and flushing
    force dut.r_stall_count = 32'hFFFF_FFFE;
    force dut.r_flush_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    release dut.r_flush_count;
    m_stall = 32'hFFFF_FFFE;
    m_flush = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++)
      run_vec(mk(0,1, 2,0, 1,0, 1,1,2, 0,0, 0,0,0, LU, 0,0,0), 100 + i);
    run_vec(mk(0,1, 0,0, 0,0, 0,0,0, 0,0, 1,0,0, BR,  0,0,0), 103);
    run_vec(mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, FRZ, 0,0,0), 104);

    if (q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
